// File: rtl/branch_issue_queue.sv
// branch_issue_queue: age-ordered reservation station for the branch unit with result-bus operand wakeup.
// Optional macro BRANCH_IQ_BYPASS_EN: an empty queue forwards a ready dispatch straight to the output in the same cycle.
package branch_iq_pkg;
    typedef logic [31:0] data_t;
    typedef logic [31:0] commit_id_t;

    typedef union packed {
        data_t      data;
        commit_id_t tag;
    } operand_content_t;

    typedef struct packed {
        logic             valid;
        operand_content_t content;
    } Operand;

    typedef struct packed {
        commit_id_t  commit_id;
        logic [31:0] pc;
        logic [31:0] target;
        logic [3:0]  op;
        Operand      src1;
        Operand      src2;
    } BranchInstr;

    typedef struct packed {
        logic       valid;
        logic       kind;
        commit_id_t commit_id;
        data_t      data;
    } Result;
endpackage

module branch_issue_queue
    import branch_iq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int N_CDB = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       in_valid,
    input  BranchInstr in_instr,
    output logic       in_ready,
    input  Result      cdb [N_CDB],
    output logic       out_valid,
    output BranchInstr out_instr,
    input  logic       out_ready
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    // A pending operand picks up the data of any valid data-kind bus carrying its producer tag.
    function automatic Operand wake_op(input Operand s, input Result [N_CDB-1:0] c);
        Operand r;
        r = s;
        for (int b = 0; b < N_CDB; b++) begin
            if (!s.valid && c[b].valid && !c[b].kind && (s.content.tag == c[b].commit_id)) begin
                r.valid        = 1'b1;
                r.content.data = c[b].data;
            end
        end
        return r;
    endfunction

    function automatic BranchInstr wake_instr(input BranchInstr i, input Result [N_CDB-1:0] c);
        BranchInstr r;
        r      = i;
        r.src1 = wake_op(i.src1, c);
        r.src2 = wake_op(i.src2, c);
        return r;
    endfunction

    BranchInstr          entries_reg  [DEPTH];
    BranchInstr          entries_next [DEPTH];
    BranchInstr          woken        [DEPTH];
    logic [DEPTH-1:0]    valid_reg;
    logic [DEPTH-1:0]    valid_next;
    logic [DEPTH-1:0]    ready_vec;
    logic [CW-1:0]       cnt_reg;
    logic [CW-1:0]       cnt_next;
    logic [CW-1:0]       wr_idx;
    logic [IW-1:0]       sel_idx;
    logic                any_ready;
    logic                bypass;
    logic                issue;
    logic                issue_q;
    logic                dispatch;
    logic                do_write;
    Result [N_CDB-1:0]   cdb_p;
    BranchInstr          in_woken;

    genvar gi;
    for (gi = 0; gi < N_CDB; gi++) begin : g_cdb
        assign cdb_p[gi] = cdb[gi];
    end

    assign in_woken = wake_instr(in_instr, cdb_p);

    for (gi = 0; gi < DEPTH; gi++) begin : g_ready
        assign woken[gi]     = wake_instr(entries_reg[gi], cdb_p);
        assign ready_vec[gi] = valid_reg[gi] && entries_reg[gi].src1.valid && entries_reg[gi].src2.valid;
    end

    // Oldest ready entry wins: scan from the youngest so the lowest index is left in place.
    always_comb begin
        any_ready = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                any_ready = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

`ifdef BRANCH_IQ_BYPASS_EN
    assign bypass = (cnt_reg == '0) && in_valid && in_woken.src1.valid && in_woken.src2.valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign in_ready  = (cnt_reg != CW'(DEPTH)) && !flush;
    assign out_valid = (any_ready || bypass) && !flush;
    assign out_instr = bypass ? in_woken : entries_reg[sel_idx];

    assign issue    = out_valid && out_ready;
    assign issue_q  = issue && !bypass;
    assign dispatch = in_valid && in_ready;
    assign do_write = dispatch && !(bypass && out_ready);
    assign wr_idx   = issue_q ? (cnt_reg - CW'(1)) : cnt_reg;
    assign cnt_next = cnt_reg + CW'(do_write) - CW'(issue_q);

    // Each slot either keeps its own (woken) contents or collapses in its younger neighbour on issue.
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic       take_next;
        logic       wr_here;
        logic       src_v;
        BranchInstr src_e;

        assign take_next = issue_q && (sel_idx <= IW'(gi));
        assign wr_here   = do_write && (wr_idx == CW'(gi));

        if (gi == DEPTH - 1) begin : g_last
            assign src_e = woken[gi];
            assign src_v = valid_reg[gi] && !take_next;
        end else begin : g_mid
            assign src_e = take_next ? woken[gi+1]     : woken[gi];
            assign src_v = take_next ? valid_reg[gi+1] : valid_reg[gi];
        end

        assign entries_next[gi] = wr_here ? in_woken : src_e;
        assign valid_next[gi]   = wr_here || src_v;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_reg <= '0;
            cnt_reg   <= '0;
        end else if (flush) begin
            valid_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            valid_reg <= valid_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Payloads carry no reset; validity lives in valid_reg.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_reg[i] <= entries_next[i];
        end
    end
endmodule

// File: tb/tb_branch_issue_queue.sv
// Directed bench for branch_issue_queue: scoreboard of expected issues, checked on every handshake.
`timescale 1ns/1ps
module tb_branch_issue_queue;
    import branch_iq_pkg::*;

    localparam int DEPTH = 4;
    localparam int N_CDB = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flush;
    logic       in_valid;
    BranchInstr in_instr;
    logic       in_ready;
    Result      cdb [N_CDB];
    logic       out_valid;
    BranchInstr out_instr;
    logic       out_ready;

    int         checks = 0;
    int         errors = 0;
    int         issued = 0;
    BranchInstr sb [$];

    always #5 clk = ~clk;

    branch_issue_queue #(.DEPTH(DEPTH), .N_CDB(N_CDB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .cdb       (cdb),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_ready (out_ready)
    );

    function automatic BranchInstr mk(input int id, input logic v1, input logic [31:0] f1,
                                      input logic v2, input logic [31:0] f2);
        BranchInstr r;
        r.commit_id         = 32'(100 + id);
        r.pc                = 32'h1000 + 32'(id * 4);
        r.target            = 32'h2000 + 32'(id * 16);
        r.op                = 4'(id);
        r.src1.valid        = v1;
        r.src1.content.data = f1;
        r.src2.valid        = v2;
        r.src2.content.data = f2;
        return r;
    endfunction

    function automatic Result bus(input logic v, input logic k, input logic [31:0] id, input logic [31:0] d);
        Result r;
        r.valid     = v;
        r.kind      = k;
        r.commit_id = id;
        r.data      = d;
        return r;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input BranchInstr obs, input BranchInstr exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cdb_idle();
        for (int b = 0; b < N_CDB; b++) cdb[b] = bus(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // One clock: handshakes are judged just before the rising edge, inputs change 1ns after it.
    task automatic tick();
        BranchInstr exp_i;
        @(negedge clk);
        if (out_valid && out_ready) begin
            chk_n("issue_expected", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_i = sb.pop_front();
                chk_i("issue_payload", out_instr, exp_i);
                $display("issue   id=%0d pc=%h src1=%h src2=%h", exp_i.commit_id, out_instr.pc,
                         out_instr.src1.content.data, out_instr.src2.content.data);
            end
            issued++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int issued_start;
        BranchInstr a;
        BranchInstr d;

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = mk(0, 1'b1, 32'h0, 1'b1, 32'h0);
        cdb_idle();
        #1;
        chk1("reset_out_valid", out_valid, 1'b0);
        chk1("reset_in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Load three entries, then assert reset asynchronously mid-stream.
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1;
            in_instr = mk(k, 1'b1, 32'(k), 1'b1, 32'(k + 8));
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk1("loaded_out_valid", out_valid, 1'b1);
        chk1("loaded_in_ready", in_ready, 1'b1);
        reset_n = 1'b0;
        #1;
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk1("midrst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk1("postrst_out_valid", out_valid, 1'b0);

        // First dispatch after reset: latency 1, or 0 with bypass.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = mk(10, 1'b1, 32'hA0, 1'b1, 32'hA1);
        sb.push_back(in_instr);
        $display("dispatch id=110 ready");
        #1;
`ifdef BRANCH_IQ_BYPASS_EN
        chk1("lat_same_cycle", out_valid, 1'b1);
`else
        chk1("lat_same_cycle", out_valid, 1'b0);
`endif
        tick();
        in_valid = 1'b0;
        #1;
`ifdef BRANCH_IQ_BYPASS_EN
        chk1("lat_bypass_empty", out_valid, 1'b0);
        chk1("lat_bypass_ready", in_ready, 1'b1);
`else
        chk1("lat_next_cycle", out_valid, 1'b1);
        tick();
`endif
        #1;
        chk1("lat_drained", out_valid, 1'b0);

        // Out-of-order readiness: A waits on tag 5, B is ready and overtakes it.
        out_ready = 1'b0;
        a = mk(20, 1'b0, 32'd5, 1'b1, 32'hA);
        in_valid = 1'b1;
        in_instr = a;
        tick();
        in_instr = mk(21, 1'b1, 32'hB, 1'b1, 32'hC);
        sb.push_back(in_instr);
        tick();
        in_valid = 1'b0;
        #1;
        chk1("ooo_b_ready", out_valid, 1'b1);
        out_ready = 1'b1;
        tick();
        #1;
        chk1("ooo_a_waiting", out_valid, 1'b0);
        cdb[0] = bus(1'b1, 1'b0, 32'd5, 32'h1234);
        sb.push_back(mk(20, 1'b1, 32'h1234, 1'b1, 32'hA));
        #1;
        chk1("ooo_wake_cycle", out_valid, 1'b0);
        tick();
        cdb_idle();
        #1;
        chk1("ooo_a_ready", out_valid, 1'b1);
        tick();
        #1;
        chk1("ooo_drained", out_valid, 1'b0);

        // A non-data result bus must not wake a pending operand.
        in_valid = 1'b1;
        in_instr = mk(30, 1'b0, 32'd7, 1'b1, 32'd3);
        tick();
        in_valid = 1'b0;
        cdb[1] = bus(1'b1, 1'b1, 32'd7, 32'hDEAD);
        tick();
        cdb_idle();
        #1;
        chk1("kind1_no_wake", out_valid, 1'b0);
        cdb[1] = bus(1'b1, 1'b0, 32'd7, 32'h55);
        sb.push_back(mk(30, 1'b1, 32'h55, 1'b1, 32'd3));
        tick();
        cdb_idle();
        #1;
        chk1("kind0_wake", out_valid, 1'b1);
        tick();

        // Full queue, then drain in age order.
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            in_valid = 1'b1;
            in_instr = mk(40 + k, 1'b1, 32'(k), 1'b1, 32'(k * 3));
            sb.push_back(in_instr);
            tick();
            #1;
            chk1("full_in_ready", in_ready, logic'(k < DEPTH - 1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk1("full_no_early_ready", in_ready, 1'b0);
        tick();
        #1;
        chk1("full_ready_returns", in_ready, 1'b1);
        repeat (DEPTH - 1) tick();
        #1;
        chk1("full_drained", out_valid, 1'b0);

        // Operand captured from a bus in the dispatch cycle itself.
        out_ready = 1'b0;
        d = mk(50, 1'b1, 32'h77, 1'b0, 32'd9);
        cdb[1]   = bus(1'b1, 1'b0, 32'd9, 32'hFFFF_FFFF);
        in_valid = 1'b1;
        in_instr = d;
        sb.push_back(mk(50, 1'b1, 32'h77, 1'b1, 32'hFFFF_FFFF));
        #1;
`ifdef BRANCH_IQ_BYPASS_EN
        chk1("capture_same_cycle", out_valid, 1'b1);
`else
        chk1("capture_same_cycle", out_valid, 1'b0);
`endif
        tick();
        in_valid = 1'b0;
        cdb_idle();
        #1;
        chk1("capture_ready_t1", out_valid, 1'b1);
        out_ready = 1'b1;
        tick();
        #1;
        chk1("capture_drained", out_valid, 1'b0);

        // Flush collides with a dispatch and an accepting branch unit.
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_instr = mk(60 + k, 1'b1, 32'(k), 1'b1, 32'(k));
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk1("preflush_out_valid", out_valid, 1'b1);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_instr  = mk(62, 1'b1, 32'h1, 1'b1, 32'h2);
        out_ready = 1'b1;
        #1;
        chk1("flush_out_valid", out_valid, 1'b0);
        chk1("flush_in_ready", in_ready, 1'b0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk1("postflush_out_valid", out_valid, 1'b0);
        chk1("postflush_in_ready", in_ready, 1'b1);
        tick();
        #1;
        chk1("flush_drop", out_valid, 1'b0);

        // Sustained one-in / one-out stream.
        out_ready    = 1'b1;
        issued_start = issued;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_instr = mk(70 + k, 1'b1, 32'(k + 100), 1'b1, 32'(k + 200));
            sb.push_back(in_instr);
            tick();
        end
        in_valid = 1'b0;
`ifdef BRANCH_IQ_BYPASS_EN
        chk_n("throughput", issued - issued_start, 6);
`else
        chk_n("throughput", issued - issued_start, 5);
`endif
        for (int w = 0; w < 10 && sb.size() != 0; w++) tick();
        chk_n("sb_drained", sb.size(), 0);
        #1;
        chk1("final_out_valid", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_issue_queue.md
# branch_issue_queue

Reservation station in front of the branch unit. Accepts dispatched `BranchInstr` packets whose operands may still be pending, captures operand values from the result buses, and issues the oldest fully-ready branch to the branch unit over a valid/ready handshake. Flushed on branch misprediction.

## Interface
- `DEPTH`, 4: number of entries (2..16).
- `N_CDB`, 2: number of result buses snooped for wakeup.
- `clk`  in  1  clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  misprediction flush; clears all entries.
- `in_valid`  in  1  dispatch request.
- `in_instr`  in  `BranchInstr`  dispatched branch; each `srcN` carries a valid bit, and either `content.data` (valid=1) or `content.tag`, the producer `commit_id` (valid=0).
- `in_ready`  out  1  queue can accept a dispatch this cycle.
- `cdb`  in  `Result [N_CDB]`  result buses; a bus with `kind == 0` and its valid bit set is a data wakeup for `commit_id`.
- `out_valid`  out  1  `out_instr` holds a branch with both operands valid.
- `out_instr`  out  `BranchInstr`  branch presented to the branch unit.
- `out_ready`  in  1  branch unit accepts.

## Operation
- Storage: `DEPTH` entries in age order, slot 0 oldest. Per entry: valid bit plus a full `BranchInstr`. Count register `cnt` (`$clog2(DEPTH+1)` bits).
- `in_ready = (cnt != DEPTH) && !flush`. Ready does not rise because a same-cycle issue frees a slot.
- Dispatch (`in_valid && in_ready`): write to slot `cnt`, or to `cnt-1` if an issue also happens this cycle.
- Dispatch-cycle capture: before the write, each pending source of `in_instr` is compared against every `cdb` bus. On a match, `data` and valid=1 are stored.
- Wakeup: each cycle, each valid entry's pending source whose tag equals a valid data `cdb.commit_id` latches that bus's data and sets valid. Multiple buses matching the same tag is illegal and unchecked. Data captures are independent of issue.
- Select: the lowest-index entry with both sources valid. `out_valid` is 1 if such an entry exists and `flush` is 0. `out_instr` is that entry, driven combinationally from registers.
- Issue (`out_valid && out_ready`): remove the selected entry and shift all younger entries down by one, preserving age order.
- Flush: `out_valid` and `in_ready` are forced to 0 in the flush cycle. Next edge: all entries invalid, `cnt = 0`. A dispatch offered in the flush cycle is dropped.
- `cnt` next = `cnt + dispatch − issue`. It never wraps; overflow is impossible by the `in_ready` rule.
- `out_instr` is don't-care when `out_valid = 0`. The bench must not check it.

## Timing
- Reset (async assert): all entry valid bits 0, `cnt = 0`. Hence `in_ready = 1` (unless `flush`) and `out_valid = 0` immediately, with no clock required. Entry payloads are not reset.
- Reset deasserting mid-operation: the queue is empty. Nothing is retained.
- Dispatch at edge t, operands ready: `out_valid` at cycle t+1 (latency 1).
- Dispatch at t with one source pending, matching cdb at cycle t+k: `out_valid` from t+k+1. If the match occurs in the dispatch cycle itself, `out_valid` from t+1.
- Throughput: one dispatch and one issue per cycle, sustained.
- `out_valid` may deassert without a handshake, but only on `flush`. Otherwise the presented entry stays the oldest ready one. An older entry becoming ready changes the selection, which is permitted.

## Configuration
- `BRANCH_IQ_BYPASS_EN` defined: when `cnt == 0`, `in_valid`, both sources of `in_instr` are valid (after dispatch-cycle capture), and `flush == 0`, then `in_instr` is presented on `out_instr` with `out_valid = 1` in the same cycle. If `out_ready`, it is consumed and not written, so latency is 0. If not `out_ready`, it is written normally.
- Not defined: no combinational in→out path. Minimum latency is 1 cycle.

## Test plan
- Reset: hold `reset_n = 0` mid-stream with 3 entries loaded, release -> `out_valid = 0`, `in_ready = 1`, `cnt = 0`. The first dispatch issues with latency 1, or 0 with bypass.
- Out-of-order readiness: dispatch A (src1 tag 5 pending), then B (ready) -> B issues first. Broadcast tag 5 with data 0x1234 -> A issues next cycle with `src1.data = 0x1234`, `src1.valid = 1`.
- Full: `DEPTH = 4`, `out_ready = 0`, dispatch 4 ready branches -> `in_ready = 0` after the 4th. Then `out_ready = 1` -> issue order is 1, 2, 3, 4, and `in_ready` returns one cycle after the first issue.
- Dispatch-cycle capture: dispatch with src2 tag 9 while `cdb[1]` broadcasts tag 9 with data 0xFFFF_FFFF -> entry is ready, `out_valid` at t+1, `src2.data = 0xFFFF_FFFF`.
- Flush collision: 2 entries, plus a dispatch and `out_ready = 1` in the flush cycle -> no handshake occurs, the dispatch is dropped, and the queue is empty at the next edge.
- Bypass (macro on): empty queue, ready dispatch, `out_ready = 1` -> `out_valid = 1` in the same cycle and `cnt` stays 0. With the macro off -> issue at t+1.
